sd_bd_arbiter: RTL and testbench

//  Buffer-descriptor (BD) store and access scheduler for the SD data path. Holds separate TX and RX

---
 rtl/sd_bd_arbiter_if.sv | 43 ++++
 rtl/sd_bd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sd_bd_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_bd_arbiter_if.sv
// Bus bundle between the SD buffer-descriptor store and its users: host
// write ports, data-master read ports and the per-direction free counts.
interface sd_bd_arbiter_if #(
  parameter int RAM_MEM_WIDTH = 32,
  parameter int BD_WIDTH      = 8
);
  logic                     host_we_tx;
  logic [RAM_MEM_WIDTH-1:0] host_dat_tx;
  logic                     host_ack_tx;
  logic                     host_we_rx;
  logic [RAM_MEM_WIDTH-1:0] host_dat_rx;
  logic                     host_ack_rx;

  logic                     re_s_tx;
  logic [RAM_MEM_WIDTH-1:0] dat_out_tx;
  logic                     ack_o_s_tx;
  logic                     a_cmp_tx;
  logic [BD_WIDTH-1:0]      free_tx_bd;

  logic                     re_s_rx;
  logic [RAM_MEM_WIDTH-1:0] dat_out_rx;
  logic                     ack_o_s_rx;
  logic                     a_cmp_rx;
  logic [BD_WIDTH-1:0]      free_rx_bd;

  // Descriptor store side.
  modport slave (
    input  host_we_tx, host_dat_tx, host_we_rx, host_dat_rx,
    input  re_s_tx, a_cmp_tx, re_s_rx, a_cmp_rx,
    output host_ack_tx, host_ack_rx,
    output dat_out_tx, ack_o_s_tx, free_tx_bd,
    output dat_out_rx, ack_o_s_rx, free_rx_bd
  );

  // Host / data-master side.
  modport master (
    output host_we_tx, host_dat_tx, host_we_rx, host_dat_rx,
    output re_s_tx, a_cmp_tx, re_s_rx, a_cmp_rx,
    input  host_ack_tx, host_ack_rx,
    input  dat_out_tx, ack_o_s_tx, free_tx_bd,
    input  dat_out_rx, ack_o_s_rx, free_rx_bd
  );
endinterface

// File: rtl/sd_bd_arbiter.sv
// Buffer-descriptor store for the SD data path. TX and RX circular BD queues
// share one single-port word RAM; four requesters (host TX/RX write, master
// TX/RX read) are granted round-robin, one RAM access per cycle.
// Requester index: 0 host TX, 1 host RX, 2 master TX, 3 master RX.
// Direction index: 0 TX, 1 RX.
module sd_bd_arbiter #(
  parameter int BD_SIZE       = 16,
  parameter int RAM_MEM_WIDTH = 32,
  parameter int BD_WIDTH      = 8
) (
  input  logic              clk,
  input  logic              rst,
  sd_bd_arbiter_if.slave    bus
);

  localparam int NBD   = BD_SIZE / 2;
  localparam int PTR_W = $clog2(NBD);
  localparam int ADR_W = $clog2(2 * BD_SIZE);

  typedef enum logic [1:0] {R_IDLE, R_WORD0, R_WORD1, R_WAIT_CMP} rd_state_e;

  // Flattened per-direction views of the bus.
  logic [1:0]               host_we;
  logic [1:0]               m_re;
  logic [1:0]               a_cmp;
  logic [RAM_MEM_WIDTH-1:0] host_dat  [2];
  logic [RAM_MEM_WIDTH-1:0] dat_out_q [2];
  logic [BD_WIDTH-1:0]      free_bd   [2];

  // Per-direction queue state.
  logic [PTR_W-1:0]         wr_ptr    [2];
  logic [PTR_W-1:0]         rd_ptr    [2];
  logic [1:0]               wr_idx;
  logic [1:0]               rd_idx;
  rd_state_e                rd_state     [2];
  rd_state_e                rd_state_nxt [2];
  logic [BD_WIDTH-1:0]      pending   [2];
  logic [1:0]               a_cmp_q;
  logic [1:0]               cmp_rise;
  logic [1:0]               commit;
  logic [1:0]               complete;
  logic [1:0]               host_gnt;
  logic [1:0]               rd_gnt;

  // Arbiter state.
  logic [3:0]               ack_q;
  logic [3:0]               elig;
  logic [1:0]               rr;
  logic [1:0]               winner;
  logic [1:0]               cand;
  logic                     gnt_valid;

  // RAM port.
  logic [RAM_MEM_WIDTH-1:0] mem [2*BD_SIZE];
  logic [ADR_W-1:0]         ram_addr;
  logic                     ram_we;
  logic [RAM_MEM_WIDTH-1:0] ram_wdata;

  assign host_we     = {bus.host_we_rx, bus.host_we_tx};
  assign m_re        = {bus.re_s_rx, bus.re_s_tx};
  assign a_cmp       = {bus.a_cmp_rx, bus.a_cmp_tx};
  assign host_dat[0] = bus.host_dat_tx;
  assign host_dat[1] = bus.host_dat_rx;

  assign bus.host_ack_tx = ack_q[0];
  assign bus.host_ack_rx = ack_q[1];
  assign bus.ack_o_s_tx  = ack_q[2];
  assign bus.ack_o_s_rx  = ack_q[3];
  assign bus.dat_out_tx  = dat_out_q[0];
  assign bus.dat_out_rx  = dat_out_q[1];
  assign bus.free_tx_bd  = free_bd[0];
  assign bus.free_rx_bd  = free_bd[1];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NBD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Eligibility per requester, queue bookkeeping and read FSM next state.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default silently infers a latch.
  always_comb begin
    elig = '0;
    for (int d = 0; d < 2; d++) begin
      rd_idx[d]   = (rd_state[d] == R_WORD1);
      cmp_rise[d] = a_cmp[d] & ~a_cmp_q[d];
      pending[d]  = BD_WIDTH'(NBD) - free_bd[d]
                    - BD_WIDTH'(rd_state[d] != R_IDLE);
      // Word1 always completes a BD already counted; word0 needs a free slot.
      elig[d]     = host_we[d] && !ack_q[d] && (wr_idx[d] || free_bd[d] != '0);
      elig[2+d]   = m_re[d] && !ack_q[2+d] &&
                    (rd_state[d] == R_WORD0 || rd_state[d] == R_WORD1);
    end
  end

  // Round-robin pick starting at rr; RAM address is {dir, ptr, word}.
  always_comb begin
    gnt_valid = 1'b0;
    winner    = rr;
    cand      = rr;
    for (int k = 0; k < 4; k++) begin
      cand = rr + 2'(k);
      if (!gnt_valid && elig[cand]) begin
        gnt_valid = 1'b1;
        winner    = cand;
      end
    end
    for (int d = 0; d < 2; d++) begin
      host_gnt[d] = gnt_valid && (winner == {1'b0, 1'(d)});
      rd_gnt[d]   = gnt_valid && (winner == {1'b1, 1'(d)});
      commit[d]   = host_gnt[d] && wr_idx[d];
      complete[d] = (rd_state[d] == R_WAIT_CMP) && cmp_rise[d];
    end
    ram_we    = gnt_valid && !winner[1];
    ram_wdata = host_dat[winner[0]];
    if (winner[1])
      ram_addr = {winner[0], rd_ptr[winner[0]], rd_idx[winner[0]]};
    else
      ram_addr = {winner[0], wr_ptr[winner[0]], wr_idx[winner[0]]};
  end

  // Master read FSM next state, one instance per direction.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rd_state_nxt[d] = rd_state[d];
      case (rd_state[d])
        R_IDLE:     if (m_re[d] && pending[d] != '0) rd_state_nxt[d] = R_WORD0;
        R_WORD0:    if (rd_gnt[d])   rd_state_nxt[d] = R_WORD1;
        R_WORD1:    if (rd_gnt[d])   rd_state_nxt[d] = R_WAIT_CMP;
        R_WAIT_CMP: if (cmp_rise[d]) rd_state_nxt[d] = R_IDLE;
        default:                     rd_state_nxt[d] = R_IDLE;
      endcase
    end
  end

  // Descriptor storage write port.
  // NOTE: the RAM array has no reset; BD contents are only meaningful once
  // written, and a reset branch would stop it mapping onto RAM cells.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // Acks, read data, pointers, free counts, FSM state and RR pointer.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= '0;
      rr      <= '0;
      a_cmp_q <= '0;
      wr_idx  <= '0;
      for (int d = 0; d < 2; d++) begin
        dat_out_q[d] <= '0;
        free_bd[d]   <= BD_WIDTH'(NBD);
        wr_ptr[d]    <= '0;
        rd_ptr[d]    <= '0;
        rd_state[d]  <= R_IDLE;
      end
    end else begin
      ack_q   <= gnt_valid ? (4'b0001 << winner) : 4'b0000;
      a_cmp_q <= a_cmp;
      if (gnt_valid) rr <= winner + 2'd1;
      for (int d = 0; d < 2; d++) begin
        rd_state[d] <= rd_state_nxt[d];
        if (host_gnt[d]) begin
          wr_idx[d] <= ~wr_idx[d];
          if (wr_idx[d]) wr_ptr[d] <= ptr_inc(wr_ptr[d]);
        end
        if (rd_gnt[d]) begin
          dat_out_q[d] <= mem[ram_addr];
          if (rd_idx[d]) rd_ptr[d] <= ptr_inc(rd_ptr[d]);
        end
        // Simultaneous commit and completion cancel out.
        case ({commit[d], complete[d]})
          2'b10:   if (free_bd[d] != '0) free_bd[d] <= free_bd[d] - 1'b1;
          2'b01:   if (free_bd[d] != BD_WIDTH'(NBD)) free_bd[d] <= free_bd[d] + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_bd_arbiter.sv
// Self-checking bench for sd_bd_arbiter. Host writes push the written word
// onto a per-direction expected queue when acked; master read acks pop and
// compare. Scenario tasks check acks, timing, rotation and free counts.
module tb_sd_bd_arbiter;
  localparam int BD_SIZE = 16;
  localparam int W       = 32;
  localparam int BW      = 8;
  localparam int NBD     = BD_SIZE / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_bd_arbiter_if #(.RAM_MEM_WIDTH(W), .BD_WIDTH(BW)) bus ();

  sd_bd_arbiter #(.BD_SIZE(BD_SIZE), .RAM_MEM_WIDTH(W), .BD_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] acks;
  logic [W-1:0] exp_tx[$];
  logic [W-1:0] exp_rx[$];

  function automatic logic [BW-1:0] free_of(input bit dir);
    return dir ? bus.free_rx_bd : bus.free_tx_bd;
  endfunction

  task automatic set_we(input bit dir, input logic v, input logic [W-1:0] d);
    if (dir) begin bus.host_we_rx = v; bus.host_dat_rx = d; end
    else     begin bus.host_we_tx = v; bus.host_dat_tx = d; end
  endtask

  task automatic set_re(input bit dir, input logic v);
    if (dir) bus.re_s_rx = v; else bus.re_s_tx = v;
  endtask

  task automatic set_cmp(input bit dir, input logic v);
    if (dir) bus.a_cmp_rx = v; else bus.a_cmp_tx = v;
  endtask

  task automatic check_free(input string name, input bit dir, input logic [BW-1:0] exp);
    checks++;
    if (free_of(dir) !== exp) begin
      errors++;
      $display("FAIL %s: free=%0d, expected %0d", name, free_of(dir), exp);
    end
  endtask

  // One clock: sample on the falling edge, run the scoreboard.
  task automatic step();
    logic [W-1:0] e;
    @(negedge clk);
    cyc++;
    acks = {bus.ack_o_s_rx, bus.ack_o_s_tx, bus.host_ack_rx, bus.host_ack_tx};
    if (bus.host_ack_tx) exp_tx.push_back(bus.host_dat_tx);
    if (bus.host_ack_rx) exp_rx.push_back(bus.host_dat_rx);
    if (bus.ack_o_s_tx) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_read_data: got %h, expected no read", bus.dat_out_tx);
      end else begin
        e = exp_tx.pop_front();
        if (bus.dat_out_tx !== e) begin
          errors++;
          $display("FAIL tx_read_data: got %h, expected %h", bus.dat_out_tx, e);
        end
      end
    end
    if (bus.ack_o_s_rx) begin
      checks++;
      if (exp_rx.size() == 0) begin
        errors++;
        $display("FAIL rx_read_data: got %h, expected no read", bus.dat_out_rx);
      end else begin
        e = exp_rx.pop_front();
        if (bus.dat_out_rx !== e) begin
          errors++;
          $display("FAIL rx_read_data: got %h, expected %h", bus.dat_out_rx, e);
        end
      end
    end
  endtask

  task automatic write_word(input bit dir, input logic [W-1:0] d);
    bit got = 0;
    set_we(dir, 1'b1, d);
    for (int i = 0; i < 16 && !got; i++) begin
      step();
      if (acks[dir]) got = 1;
    end
    set_we(dir, 1'b0, '0);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL host_ack dir%0d: no ack in 16 cycles for %h, expected ack", dir, d);
    end
  endtask

  task automatic read_words(input bit dir);
    int n = 0;
    set_re(dir, 1'b1);
    for (int i = 0; i < 24 && n < 2; i++) begin
      step();
      if (acks[2+dir]) n++;
    end
    set_re(dir, 1'b0);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL read_acks dir%0d: got %0d acks, expected 2", dir, n);
    end
  endtask

  task automatic pulse_cmp(input bit dir);
    set_cmp(dir, 1'b1);
    step();
    set_cmp(dir, 1'b0);
    step();
  endtask

  task automatic read_bd(input bit dir);
    read_words(dir);
    pulse_cmp(dir);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_we(0, 1'b0, '0); set_we(1, 1'b0, '0);
    set_re(0, 1'b0); set_re(1, 1'b0);
    set_cmp(0, 1'b0); set_cmp(1, 1'b0);
    step(); step();
    checks++;
    if ({bus.host_ack_tx, bus.host_ack_rx, bus.ack_o_s_tx, bus.ack_o_s_rx} !== 4'b0) begin
      errors++;
      $display("FAIL reset_acks: got %b, expected 0000",
               {bus.host_ack_tx, bus.host_ack_rx, bus.ack_o_s_tx, bus.ack_o_s_rx});
    end
    checks++;
    if (bus.dat_out_tx !== '0 || bus.dat_out_rx !== '0) begin
      errors++;
      $display("FAIL reset_dat_out: got %h/%h, expected 0", bus.dat_out_tx, bus.dat_out_rx);
    end
    check_free("reset_free_tx", 0, BW'(NBD));
    check_free("reset_free_rx", 1, BW'(NBD));
    exp_tx.delete(); exp_rx.delete();
    rst = 1'b0;
    step();
  endtask

  task automatic test_host_write();
    write_word(0, 32'h0000_1000);
    check_free("wr_word0_free", 0, 8'd8);
    write_word(0, 32'h0000_0200);
    check_free("wr_commit_free", 0, 8'd7);
  endtask

  task automatic test_master_read();
    int n = 0;
    int c0 = 0;
    int c1 = 0;
    set_re(0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step();
      if (acks[2]) begin
        n++;
        if (n == 1) c0 = cyc; else if (n == 2) c1 = cyc;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL rd_ack_count: got %0d acks with re held, expected 2", n);
    end
    checks++;
    if (c1 - c0 < 2) begin
      errors++;
      $display("FAIL rd_ack_spacing: got %0d cycles, expected >= 2", c1 - c0);
    end
    check_free("rd_locked_free", 0, 8'd7);
    pulse_cmp(0);
    check_free("rd_cmp_free", 0, 8'd8);
    set_re(0, 1'b0);
    step();
  endtask

  task automatic test_round_robin();
    int seq[8];
    int nseq = 0;
    int cnt[4] = '{0, 0, 0, 0};
    bit multi = 0;
    write_word(0, 32'hA000_0000); write_word(0, 32'hA000_0001);
    write_word(1, 32'hB000_0000); write_word(1, 32'hB000_0001);
    // Move both read FSMs into their word0 state without granting.
    set_re(0, 1'b1); set_re(1, 1'b1);
    step();
    set_re(0, 1'b0); set_re(1, 1'b0);
    step();
    set_we(0, 1'b1, 32'hA100_0000); set_we(1, 1'b1, 32'hB100_0000);
    set_re(0, 1'b1); set_re(1, 1'b1);
    for (int i = 0; i < 16 && nseq < 8; i++) begin
      step();
      if ($countones(acks) > 1) multi = 1;
      for (int r = 0; r < 4; r++) begin
        if (acks[r]) begin
          if (nseq < 8) seq[nseq] = r;
          nseq++;
          cnt[r]++;
        end
      end
      if (acks[0]) begin
        if (cnt[0] == 2) set_we(0, 1'b0, '0); else set_we(0, 1'b1, 32'hA100_0001);
      end
      if (acks[1]) begin
        if (cnt[1] == 2) set_we(1, 1'b0, '0); else set_we(1, 1'b1, 32'hB100_0001);
      end
      if (acks[2] && cnt[2] == 2) set_re(0, 1'b0);
      if (acks[3] && cnt[3] == 2) set_re(1, 1'b0);
    end
    set_we(0, 1'b0, '0); set_we(1, 1'b0, '0);
    set_re(0, 1'b0); set_re(1, 1'b0);
    checks++;
    if (nseq != 8 || multi) begin
      errors++;
      $display("FAIL rr_grants: got %0d grants (multi=%0d), expected 8 single", nseq, multi);
    end
    for (int i = 1; i < 8 && i < nseq; i++) begin
      checks++;
      if (seq[i] != (seq[i-1] + 1) % 4) begin
        errors++;
        $display("FAIL rr_order[%0d]: got requester %0d, expected %0d",
                 i, seq[i], (seq[i-1] + 1) % 4);
      end
    end
    check_free("rr_free_tx", 0, 8'd6);
    check_free("rr_free_rx", 1, 8'd6);
    set_cmp(0, 1'b1); set_cmp(1, 1'b1);
    step();
    set_cmp(0, 1'b0); set_cmp(1, 1'b0);
    step();
    check_free("rr_cmp_tx", 0, 8'd7);
    check_free("rr_cmp_rx", 1, 8'd7);
    read_bd(0);
    read_bd(1);
    check_free("rr_drain_tx", 0, 8'd8);
    check_free("rr_drain_rx", 1, 8'd8);
  endtask

  task automatic test_full_wrap();
    bit got = 0;
    int stall_acks = 0;
    logic [BW-1:0] f_at_ack = '0;
    for (int b = 0; b < NBD; b++) begin
      write_word(0, 32'hC000_0000 + 32'(2 * b));
      write_word(0, 32'hC000_0001 + 32'(2 * b));
    end
    check_free("full_free", 0, 8'd0);
    read_words(0);
    set_we(0, 1'b1, 32'hC900_0000);
    for (int i = 0; i < 6; i++) begin
      step();
      if (acks[0]) stall_acks++;
    end
    checks++;
    if (stall_acks != 0) begin
      errors++;
      $display("FAIL full_stall: got %0d acks, expected 0", stall_acks);
    end
    set_cmp(0, 1'b1);
    step();
    set_cmp(0, 1'b0);
    if (acks[0]) begin got = 1; f_at_ack = free_of(0); end
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (acks[0]) begin got = 1; f_at_ack = free_of(0); end
    end
    set_we(0, 1'b0, '0);
    checks++;
    if (!got || f_at_ack !== 8'd1) begin
      errors++;
      $display("FAIL wrap_word0: ack=%0d free=%0d, expected ack=1 free=1", got, f_at_ack);
    end
    write_word(0, 32'hC900_0001);
    check_free("wrap_commit_free", 0, 8'd0);
    for (int b = 0; b < NBD; b++) read_bd(0);
    check_free("wrap_drain_free", 0, 8'd8);
    checks++;
    if (exp_tx.size() != 0) begin
      errors++;
      $display("FAIL wrap_drain_queue: %0d words left, expected 0", exp_tx.size());
    end
  endtask

  task automatic test_commit_cmp_same_cycle();
    for (int b = 0; b < 3; b++) begin
      write_word(1, 32'hD000_0000 + 32'(2 * b));
      write_word(1, 32'hD000_0001 + 32'(2 * b));
    end
    check_free("cc_free5", 1, 8'd5);
    read_words(1);
    write_word(1, 32'hD300_0000);
    set_we(1, 1'b1, 32'hD300_0001);
    step();
    set_cmp(1, 1'b1);
    step();
    checks++;
    if (!acks[1]) begin
      errors++;
      $display("FAIL cc_commit_ack: got ack=0, expected 1");
    end
    check_free("cc_same_cycle", 1, 8'd5);
    set_we(1, 1'b0, '0);
    set_cmp(1, 1'b0);
    step();
    check_free("cc_after", 1, 8'd5);
    for (int b = 0; b < 3; b++) read_bd(1);
    check_free("cc_drain", 1, 8'd8);
    pulse_cmp(1);
    check_free("cc_spurious", 1, 8'd8);
  endtask

  task automatic test_reset_mid_read();
    bit got = 0;
    write_word(0, 32'h6000_0000);
    write_word(0, 32'h6000_0001);
    set_re(0, 1'b1);
    for (int i = 0; i < 16 && !got; i++) begin
      step();
      if (acks[2]) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL mid_word0: no read ack in 16 cycles, expected ack");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ack_o_s_tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ack: got %b, expected 0", bus.ack_o_s_tx);
    end
    check_free("mid_rst_free_tx", 0, 8'd8);
    exp_tx.delete(); exp_rx.delete();
    set_re(0, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    write_word(0, 32'h7000_0000);
    write_word(0, 32'h7000_0001);
    read_bd(0);
    check_free("post_rst_free", 0, 8'd8);
    checks++;
    if (exp_tx.size() != 0) begin
      errors++;
      $display("FAIL post_rst_queue: %0d words left, expected 0", exp_tx.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_host_write();
    test_master_read();
    test_round_robin();
    test_reset();
    test_full_wrap();
    test_commit_cmp_same_cycle();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
